// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches one cache block word-by-word from backing memory into the data array, then writes the tag.
// Latency: requests on cycles 1..BLOCK_WORDS after the miss edge; tag write on cycle BLOCK_WORDS+L (L = memory latency).
// Backpressure: none toward memory (one unthrottled read per cycle); fsm_busy stalls the pipeline for the whole fill.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            miss_detected,
    input  logic [ADDR_WIDTH-1:0]           miss_address,
    input  logic                            memory_data_valid,
    input  logic [15:0]                     memory_data,
    output logic                            fsm_busy,
    output logic                            mem_en,
    output logic [ADDR_WIDTH-1:0]           memory_address,
    output logic                            write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0]  word_offset,
    output logic [15:0]                     fill_data,
    output logic                            write_tag_array
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = OFF_W + 1;

    // Counters run 0..BLOCK_WORDS, so they need one bit more than the word offset.
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
    // Byte-offset bits inside a block (word offset plus the halfword byte bit).
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [CNT_W-1:0]      issue_cnt, issue_nxt;
    logic [CNT_W-1:0]      recv_cnt, recv_nxt;

    // State, block base and both word counters; synchronous reset aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
        end
    end

    // Next-state and outputs: issue side and receive side advance independently during FILL.
    always_comb begin
        state_nxt        = state;
        base_nxt         = base;
        issue_nxt        = issue_cnt;
        recv_nxt         = recv_cnt;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_offset      = recv_cnt[OFF_W-1:0];
        fill_data        = memory_data;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_nxt = FILL;
                    base_nxt  = miss_address & ~BLK_MASK;
                    issue_nxt = '0;
                    recv_nxt  = '0;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;

                // Offset bits come only from the low counter bits, so the
                // address never carries into the tag (no wrap at top of memory).
                mem_en         = (issue_cnt < CNT_FULL);
                memory_address = base | (ADDR_WIDTH'(issue_cnt[OFF_W-1:0]) << 1);
                if (mem_en) begin
                    issue_nxt = issue_cnt + CNT_W'(1);
                end

                write_data_array = memory_data_valid && (recv_cnt < CNT_FULL);
                if (write_data_array) begin
                    recv_nxt = recv_cnt + CNT_W'(1);
                end

                // Last word in: strobe the tag and drop the stall on the same edge.
                write_tag_array = write_data_array && (recv_cnt == CNT_LAST);
                if (write_tag_array) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: randomized fills against a fixed-latency memory model and timing expectations.
// Latency: expectations are cycle-indexed from the miss edge (requests 1..BW, writes 1+L..BW+L).
// Backpressure: none; memory answers every request exactly L cycles later.
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int tests = 0;
    int fails = 0;

    cache_fill_fsm #(
        .BLOCK_WORDS(BW),
        .ADDR_WIDTH (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .mem_en           (mem_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .word_offset      (word_offset),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle cycles with spurious valid pulses; nothing may be written or requested.
    task automatic idle_cycles(input int cnt, input string name);
        for (int k = 0; k < cnt; k++) begin
            miss_detected     = 1'b0;
            miss_address      = 16'($urandom);
            memory_data_valid = 1'($urandom_range(0, 1));
            memory_data       = 16'($urandom);
            @(negedge clk);
            tests++;
            if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0000) begin
                fails++;
                $display("FAIL %s idle strobes: got busy/en/wr/tag=%b want 0000", name,
                         {fsm_busy, mem_en, write_data_array, write_tag_array});
            end
            tests++;
            if (memory_address !== 16'h0000) begin
                fails++;
                $display("FAIL %s idle addr: got %h want 0000", name, memory_address);
            end
            @(posedge clk);
            #1;
        end
        memory_data_valid = 1'b0;
    endtask

    // One complete fill. Entered and left #1 after a rising edge, in an IDLE cycle.
    // busy_miss re-asserts a miss (0x5678) on cycles 2..10; abort_after>0 resets after that many writes.
    task automatic do_fill(input logic [15:0] addr, input int lat, input bit busy_miss,
                           input int abort_after, input string name);
        int          due_q[$];
        logic [15:0] dat_q[$];
        int          base;
        int          last;
        int          writes;
        bit          vld;

        base   = (int'(addr) / (2 * BW)) * (2 * BW);
        last   = BW + lat;
        writes = 0;

        // Cycle 0: miss presented while IDLE.
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        @(negedge clk);
        tests++;
        if ({fsm_busy, mem_en, write_tag_array} !== 3'b000) begin
            fails++;
            $display("FAIL %s cycle0 idle: got busy/en/tag=%b want 000", name,
                     {fsm_busy, mem_en, write_tag_array});
        end

        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            miss_detected     = busy_miss && (n >= 2) && (n <= 10);
            miss_address      = busy_miss ? 16'h5678 : 16'($urandom);
            vld               = (due_q.size() > 0) && (due_q[0] == n);
            memory_data_valid = vld;
            memory_data       = vld ? dat_q[0] : 16'($urandom);
            @(negedge clk);

            tests++;
            if (fsm_busy !== 1'b1) begin
                fails++;
                $display("FAIL %s busy cyc %0d: got %b want 1", name, n, fsm_busy);
            end
            tests++;
            if (mem_en !== (n <= BW)) begin
                fails++;
                $display("FAIL %s mem_en cyc %0d: got %b want %b", name, n, mem_en, (n <= BW));
            end
            if (n <= BW) begin
                tests++;
                if (memory_address !== 16'(base + 2 * (n - 1))) begin
                    fails++;
                    $display("FAIL %s addr cyc %0d: got %h want %h", name, n, memory_address,
                             16'(base + 2 * (n - 1)));
                end
            end
            tests++;
            if (write_data_array !== (n > lat)) begin
                fails++;
                $display("FAIL %s write cyc %0d: got %b want %b", name, n, write_data_array, (n > lat));
            end
            if (n > lat) begin
                tests++;
                if (word_offset !== 3'(n - 1 - lat)) begin
                    fails++;
                    $display("FAIL %s offset cyc %0d: got %0d want %0d", name, n, word_offset, n - 1 - lat);
                end
            end
            tests++;
            if (fill_data !== memory_data) begin
                fails++;
                $display("FAIL %s fill_data cyc %0d: got %h want %h", name, n, fill_data, memory_data);
            end
            tests++;
            if (write_tag_array !== (n == last)) begin
                fails++;
                $display("FAIL %s tag cyc %0d: got %b want %b", name, n, write_tag_array, (n == last));
            end

            // Memory model: answer each request after exactly lat cycles, in order.
            if (mem_en === 1'b1) begin
                due_q.push_back(n + lat);
                dat_q.push_back(16'($urandom));
            end
            if (vld) begin
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (write_data_array === 1'b1) writes++;

            if (abort_after > 0 && writes == abort_after) begin
                @(posedge clk);
                #1;
                rst               = 1'b1;
                miss_detected     = 1'b0;
                memory_data_valid = 1'b1;
                memory_data       = 16'($urandom);
                @(posedge clk);
                #1;
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    memory_data_valid = 1'b1;
                    memory_data       = 16'($urandom);
                    @(negedge clk);
                    tests++;
                    if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0000) begin
                        fails++;
                        $display("FAIL %s post-abort k=%0d: got busy/en/wr/tag=%b want 0000", name, k,
                                 {fsm_busy, mem_en, write_data_array, write_tag_array});
                    end
                    tests++;
                    if (memory_address !== 16'h0000) begin
                        fails++;
                        $display("FAIL %s post-abort addr k=%0d: got %h want 0000", name, k, memory_address);
                    end
                    @(posedge clk);
                    #1;
                end
                memory_data_valid = 1'b0;
                return;
            end
        end

        @(posedge clk);
        #1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        miss_detected     = 1'b1;
        miss_address      = 16'h1234;
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0000) begin
            fails++;
            $display("FAIL reset strobes: got busy/en/wr/tag=%b want 0000",
                     {fsm_busy, mem_en, write_data_array, write_tag_array});
        end
        tests++;
        if (memory_address !== 16'h0000) begin
            fails++;
            $display("FAIL reset addr: got %h want 0000", memory_address);
        end
        tests++;
        if (word_offset !== 3'd0) begin
            fails++;
            $display("FAIL reset offset: got %0d want 0", word_offset);
        end
        tests++;
        if (fill_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL reset fill_data: got %h want beef", fill_data);
        end
        @(posedge clk);
        #1;
        rst               = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_basic_fill();
        do_fill(16'h1234, 4, 1'b0, 0, "basic");
        idle_cycles(2, "basic_idle");
    endtask

    task automatic test_miss_while_busy();
        do_fill(16'h1234, 4, 1'b1, 0, "busy_miss");
        idle_cycles(2, "busy_miss_idle");
    endtask

    task automatic test_reset_mid_fill();
        do_fill(16'h0A12, 4, 1'b0, 3, "abort");
        do_fill(16'h0040, 4, 1'b0, 0, "after_abort");
        idle_cycles(1, "after_abort_idle");
    endtask

    task automatic test_top_of_memory();
        do_fill(16'hFFF6, 3, 1'b0, 0, "top_mem");
        idle_cycles(1, "top_mem_idle");
    endtask

    task automatic test_back_to_back();
        do_fill(16'h2000, 1, 1'b0, 0, "b2b_0");
        do_fill(16'h2010, 1, 1'b0, 0, "b2b_1");
        do_fill(16'h2468, 1, 1'b0, 0, "b2b_2");
        idle_cycles(1, "b2b_idle");
    endtask

    task automatic test_random_fills();
        for (int i = 0; i < 24; i++) begin
            do_fill(16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0, "random");
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "random_idle");
        end
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;

        test_reset();
        test_basic_fill();
        test_miss_while_busy();
        test_reset_mid_fill();
        test_top_of_memory();
        test_back_to_back();
        test_random_fills();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a direct-mapped cache and the 16-bit, byte-addressed, word-aligned backing memory. On a cache miss it latches the block address, issues one pipelined word read per cycle for every word of the block, and steers each returned word into the cache data array by word offset. On the final word it strobes the tag array, then releases the pipeline stall.

## Interface
- BLOCK_WORDS, 8, number of 16-bit words per cache block; must be a power of 2, at least 2.
- ADDR_WIDTH, 16, byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- miss_detected  in  1  cache lookup missed; sampled only in IDLE.
- miss_address  in  ADDR_WIDTH  byte address of the missing access; low log2(BLOCK_WORDS)+1 bits ignored.
- memory_data_valid  in  1  backing memory returns a read word this cycle.
- memory_data  in  16  returned read word.
- fsm_busy  out  1  fill in progress; the stall request to the pipeline.
- mem_en  out  1  read request to backing memory (wr held 0 by the integrator).
- memory_address  out  ADDR_WIDTH  byte address of the current request; bit 0 always 0.
- write_data_array  out  1  write strobe to the cache data array.
- word_offset  out  log2(BLOCK_WORDS)  data-array word index for the current write.
- fill_data  out  16  word to write; combinational copy of memory_data.
- write_tag_array  out  1  tag/valid write strobe, one cycle.

## Operation
- States: IDLE and FILL. Registered state: state, base (block address), issue_cnt and recv_cnt, each 0..BLOCK_WORDS.
- IDLE: when miss_detected=1, latch base = miss_address with the offset bits cleared, clear both counters, and go to FILL. Otherwise stay.
- FILL issue side:
  - mem_en = (issue_cnt < BLOCK_WORDS).
  - memory_address = base | (issue_cnt << 1).
  - issue_cnt increments on every cycle mem_en=1 and saturates at BLOCK_WORDS.
  - Requests are not throttled. The memory accepts one read per cycle and returns data in order.
- FILL receive side:
  - write_data_array = memory_data_valid & (recv_cnt < BLOCK_WORDS).
  - word_offset = recv_cnt[low bits].
  - recv_cnt increments on each write.
  - write_tag_array = write_data_array & (recv_cnt == BLOCK_WORDS-1).
  - The next state is IDLE on that same edge.
- fsm_busy = (state == FILL).
- mem_en, write_data_array and write_tag_array are 0 in IDLE. memory_address is 0 in IDLE.
- Address arithmetic stays inside the block: offset bits come only from issue_cnt, so there is no carry into the tag bits. Blocks at the top of memory (e.g. 0xFFF0) do not wrap.

## Timing
- Reset: state=IDLE; base, issue_cnt, recv_cnt = 0. Every output is 0 in the cycle after the reset edge, except fill_data, which tracks memory_data.
- Reset while in FILL aborts the fill. There is no tag write. memory_data_valid pulses that arrive later in IDLE are ignored.
- Miss sampled at edge 0: FILL from cycle 1. Requests go out on cycles 1..BLOCK_WORDS.
- With memory latency L, data writes occur on cycles 1+L..BLOCK_WORDS+L. The tag strobe is on cycle BLOCK_WORDS+L. fsm_busy falls on the following cycle.
- miss_detected while in FILL is ignored. A miss in the first IDLE cycle after a fill starts a new fill.
- memory_data_valid in IDLE, or after BLOCK_WORDS words, is ignored.
- Receives may overlap issues. Both counters advance in the same cycle independently.

## Test plan
- Reset check: assert rst with miss_detected=1 and memory_data_valid=1 → after the edge, fsm_busy, mem_en, write_data_array and write_tag_array are all 0, and memory_address=0x0000.
- Basic fill: miss 0x1234, memory latency 4 → memory_address 0x1230,0x1232,…,0x123E on cycles 1–8; write_data_array on cycles 5–12 with word_offset 0–7 and fill_data equal to memory_data; write_tag_array only on cycle 12; fsm_busy high on cycles 1–12.
- Miss while busy: second miss 0x5678 asserted on cycles 2–10 → no change to addresses or counters; the fill completes as in the basic fill.
- Reset mid-fill: assert rst after 3 words are written → IDLE next cycle, no tag strobe, late valid pulses produce no writes; a new miss 0x0040 then writes offsets 0–7 starting from 0.
- Top-of-memory block: miss 0xFFF6 → addresses 0xFFF0–0xFFFE, no wrap to 0x0000.
- Back-to-back misses with latency 1: miss asserted on the first IDLE cycle after fsm_busy falls → a new fill starts the next cycle; writes are contiguous with offsets 0–7.
